// File: rtl/chaotic_pixel_cipher.sv
// XOR-chained pixel cipher keyed by a 3-D chaotic sequence.
// Keys are buffered in a small FIFO and each accepted pixel consumes exactly one key.
module chaotic_pixel_cipher #(
  parameter int         TOTAL_BITS     = 32,
  parameter int         IMG_WIDTH      = 64,
  parameter int         IMG_HEIGHT     = 64,
  parameter int         WARMUP_SAMPLES = 1000,
  parameter int         KEY_FIFO_DEPTH = 4,
  parameter logic [7:0] IV             = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [TOTAL_BITS-1:0] x_seq,
  input  logic [TOTAL_BITS-1:0] y_seq,
  input  logic [TOTAL_BITS-1:0] z_seq,
  input  logic                  seq_valid,
  input  logic [7:0]            pix_in,
  input  logic                  pix_in_valid,
  output logic                  pix_in_ready,
  output logic [7:0]            pix_out,
  output logic                  pix_out_valid,
  input  logic                  pix_out_ready,
  output logic                  pix_out_last
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int WARM_W    = $clog2(WARMUP_SAMPLES + 1);
  localparam int PTR_W     = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(KEY_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] key_of(input logic [7:0] xb, input logic [7:0] yb,
                                        input logic [7:0] zb);
    return xb ^ yb ^ zb;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(KEY_FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  state_t            state_r, next_state_s;
  logic [WARM_W-1:0] warm_cnt_r;
  logic [PIX_W-1:0]  pix_cnt_r;
  logic              all_in_r;
  logic [7:0]        prev_c_r;
  logic [7:0]        key_mem_r [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic [7:0]        pix_out_r;
  logic              pix_out_valid_r, pix_out_last_r;
  logic              ap_ready_r, ap_done_r;

  logic       start_s, fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic       in_ready_s, in_hs_s, out_hs_s, warm_last_s;
  logic [7:0] key_s, cipher_s;
  logic       unused_seq_bits_s;

  assign unused_seq_bits_s = ^{x_seq[TOTAL_BITS-1:16], x_seq[7:0],
                               y_seq[TOTAL_BITS-1:16], y_seq[7:0],
                               z_seq[TOTAL_BITS-1:16], z_seq[7:0]};

  assign start_s      = (state_r == ST_IDLE) && ap_start;
  assign key_s        = key_of(x_seq[15:8], y_seq[15:8], z_seq[15:8]);
  assign fifo_full_s  = (fifo_cnt_r == CNT_W'(KEY_FIFO_DEPTH));
  assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
  assign push_s       = (state_r == ST_RUN) && seq_valid && !fifo_full_s;
  assign out_hs_s     = pix_out_valid_r && pix_out_ready;
  // all_in_r stands in for "counter reached frame size" so the counter never wraps
  assign in_ready_s   = (state_r == ST_RUN) && !fifo_empty_s &&
                        (!pix_out_valid_r || pix_out_ready) && !all_in_r;
  assign in_hs_s      = pix_in_valid && in_ready_s;
  assign pop_s        = in_hs_s;
  assign warm_last_s  = (warm_cnt_r == WARM_W'(WARMUP_SAMPLES - 1));
  assign cipher_s     = pix_in ^ key_mem_r[rd_ptr_r] ^ prev_c_r;

  assign ap_ready      = ap_ready_r;
  assign ap_done       = ap_done_r;
  assign pix_in_ready  = in_ready_s;
  assign pix_out       = pix_out_r;
  assign pix_out_valid = pix_out_valid_r;
  assign pix_out_last  = pix_out_last_r;

  // Next-state decode of the frame controller.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ap_start) begin
          next_state_s = ST_WARMUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (seq_valid && warm_last_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        if (out_hs_s && pix_out_last_r) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with registered ap_ready/ap_done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ap_ready_r <= 1'b1;
      ap_done_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      ap_ready_r <= (next_state_s == ST_IDLE);
      ap_done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Key FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < KEY_FIFO_DEPTH; i++) begin
        key_mem_r[i] <= 8'h00;
      end
    end else if (start_s) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        key_mem_r[wr_ptr_r] <= key_s;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Warmup/pixel counters and the ciphertext chaining register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt_r <= {WARM_W{1'b0}};
      pix_cnt_r  <= {PIX_W{1'b0}};
      all_in_r   <= 1'b0;
      prev_c_r   <= IV;
    end else if (start_s) begin
      warm_cnt_r <= {WARM_W{1'b0}};
      pix_cnt_r  <= {PIX_W{1'b0}};
      all_in_r   <= 1'b0;
      prev_c_r   <= IV;
    end else begin
      if ((state_r == ST_WARMUP) && seq_valid) begin
        warm_cnt_r <= warm_cnt_r + WARM_W'(1);
      end
      if (in_hs_s) begin
        prev_c_r <= cipher_s;
        if (pix_cnt_r == PIX_W'(FRAME_PIX - 1)) begin
          all_in_r <= 1'b1;
        end else begin
          pix_cnt_r <= pix_cnt_r + PIX_W'(1);
        end
      end
    end
  end

  // Output register: holds until the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out_r       <= 8'h00;
      pix_out_valid_r <= 1'b0;
      pix_out_last_r  <= 1'b0;
    end else if (in_hs_s) begin
      pix_out_r       <= cipher_s;
      pix_out_valid_r <= 1'b1;
      pix_out_last_r  <= (pix_cnt_r == PIX_W'(FRAME_PIX - 1));
    end else if (out_hs_s) begin
      pix_out_valid_r <= 1'b0;
      pix_out_last_r  <= 1'b0;
    end
  end

endmodule

// File: doc/chaotic_pixel_cipher.md
CHAOTIC_PIXEL_CIPHER -- requirements
Module: chaotic_pixel_cipher

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- TOTAL_BITS, 32, width of each chaotic sample (sign + 6 integer + 25 fraction bits).
- IMG_WIDTH, 64, pixels per row.
- IMG_HEIGHT, 64, rows per frame.
- WARMUP_SAMPLES, 1000, chaotic samples discarded at frame start.
- KEY_FIFO_DEPTH, 4, key buffer entries.
- IV, 8'hA5, chaining seed at frame start.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all logic uses its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- ap_start  in  1  frame start request.
- ap_ready  out  1  high while idle.
- ap_done  out  1  one-cycle end-of-frame pulse.
- x_seq, y_seq, z_seq  in  TOTAL_BITS each  signed chaotic state samples.
- seq_valid  in  1  x/y/z_seq valid this cycle.
- pix_in  in  8  plaintext pixel.
- pix_in_valid  in  1  plaintext pixel valid.
- pix_in_ready  out  1  plaintext pixel accepted when high together with pix_in_valid.
- pix_out  out  8  ciphertext pixel.
- pix_out_valid  out  1  ciphertext pixel valid.
- pix_out_ready  in  1  downstream accepts the ciphertext pixel.
- pix_out_last  out  1  marks the final pixel of the frame.

Function
REQ-003 The FSM SHALL have four states: IDLE, WARMUP, RUN, DONE.
REQ-004 Transitions:
- IDLE to WARMUP on ap_start=1; this also clears the warmup counter, pixel counter and key FIFO, and loads prev_c with IV.
- ap_start SHALL be ignored in all states other than IDLE.
REQ-005 In WARMUP, each cycle with seq_valid=1 SHALL increment the warmup counter; after the WARMUP_SAMPLES-th such sample the FSM SHALL enter RUN. No key is written during WARMUP.
REQ-006 Key derivation: key = x_seq[15:8] ^ y_seq[15:8] ^ z_seq[15:8], computed from the raw bit vectors.
REQ-007 Key FIFO writes:
- In RUN, each cycle with seq_valid=1 and FIFO not full SHALL push the key.
- When the FIFO is full, the sample SHALL be dropped with no error.
REQ-008 pix_in_ready SHALL equal (state==RUN) && (FIFO not empty) && (!pix_out_valid || pix_out_ready) && (pixel counter < IMG_WIDTH*IMG_HEIGHT).
REQ-009 On a pixel handshake (pix_in_valid && pix_in_ready):
- c = pix_in ^ key_head ^ prev_c.
- Pop the FIFO.
- Register c onto pix_out and set pix_out_valid=1 on the next edge.
- prev_c <= c.
- Increment the pixel counter.
- Latency from input handshake to output valid: 1 cycle.
REQ-010 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged. An empty FIFO SHALL never be popped.
REQ-011 pix_out_valid and pix_out SHALL be held stable until pix_out_ready=1. pix_out_valid SHALL clear on that handshake unless a new pixel is accepted in the same cycle.
REQ-012 pix_out_last SHALL be 1 exactly with the pixel whose index is IMG_WIDTH*IMG_HEIGHT-1.
REQ-013 After the output handshake of the last pixel, the FSM SHALL go RUN to DONE. DONE SHALL assert ap_done for exactly one cycle, then return to IDLE.
REQ-014 ap_ready SHALL be 1 only in IDLE.
REQ-015 The pixel counter SHALL be 12 bits at the default parameters, sized as clog2(IMG_WIDTH*IMG_HEIGHT). It SHALL not wrap within a frame; acceptance stops at the frame size per REQ-008.

Reset
REQ-016 rst_n=0 SHALL asynchronously and immediately force:
- state=IDLE.
- ap_ready=1, ap_done=0.
- pix_out_valid=0, pix_out=0, pix_out_last=0, pix_in_ready=0.
- FIFO empty; all counters 0; prev_c=IV.
REQ-017 Reset asserted mid-frame SHALL abandon the frame with no ap_done. The next frame SHALL require a new ap_start.

Verification (WARMUP_SAMPLES=4, IMG_WIDTH=4, IMG_HEIGHT=2 unless stated)
REQ-018 Warmup: ap_start pulse, then seq_valid high continuously.
- ap_ready falls the cycle after ap_start.
- The first 4 samples are not keyed.
- pix_in_ready rises only after the 5th sample has been pushed.
REQ-019 Cipher values: x_seq=32'h0000_1200, y_seq=32'h0000_3400, z_seq=0, giving key 8'h26.
- Pixel 8'h00 -> pix_out 8'h83.
- Next pixel 8'hFF -> pix_out 8'h5A.
REQ-020 Backpressure: hold pix_out_ready=0 for 5 cycles.
- pix_out is stable and pix_in_ready=0 throughout.
- The FIFO stays at 4 entries and excess samples are dropped.
- On release, data resumes with no loss or duplication.
REQ-021 Key starvation: seq_valid=0 in RUN.
- pix_in_ready falls once the FIFO empties.
- A single seq_valid pulse enables exactly one pixel.
REQ-022 Frame end:
- The 8th output carries pix_out_last=1.
- ap_done pulses once, 1 cycle after its handshake.
- ap_ready=1 the following cycle.
- An ap_start during RUN has no effect.
REQ-023 Reset after pixel 3: all outputs return to their reset values in the same cycle. A new ap_start restarts the frame with prev_c=8'hA5 and pixel index 0.
